// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and pixel-fetch controller.
//
// A stage-0 column/row counter pair walks the full raster. Region flags (sync, visible,
// window, frame start) are decoded combinationally from the counters, delayed by MEM_LATENCY
// enabled cycles to line up with the video-memory read data, then registered together with
// the colour. A linear read address counts through the display window.
//
// Ports:
//   Clock, Reset        system clock, asynchronous active-high reset
//   iPixelEn            pixel-clock enable; all state advances only when high
//   oReadAddress        video-memory read address for the current stage-0 pixel
//   iColor              {R,G,B} read data, valid MEM_LATENCY enabled cycles after its address
//   oVGA_Red/Green/Blue pixel colour, zero outside the window
//   oHSync, oVSync      sync outputs, active level HS_POL / VS_POL
//   oActive             output pixel is inside the visible area
//   oFrameStart         one-enabled-cycle pulse with output pixel (0,0)
//   oColumn, oRow       stage-0 counters
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned WIN_X0      = 64,
    parameter int unsigned WIN_X1      = 575,
    parameter int unsigned WIN_Y0      = 48,
    parameter int unsigned WIN_Y1      = 431,
    parameter int unsigned COLOR_W     = 1,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iPixelEn,
    output logic [ADDR_W-1:0]    oReadAddress,
    input  logic [3*COLOR_W-1:0] iColor,
    output logic [COLOR_W-1:0]   oVGA_Red,
    output logic [COLOR_W-1:0]   oVGA_Green,
    output logic [COLOR_W-1:0]   oVGA_Blue,
    output logic                 oHSync,
    output logic                 oVSync,
    output logic                 oActive,
    output logic                 oFrameStart,
    output logic [9:0]           oColumn,
    output logic [9:0]           oRow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] WX0        = 10'(WIN_X0);
    localparam logic [9:0] WX1        = 10'(WIN_X1);
    localparam logic [9:0] WY0        = 10'(WIN_Y0);
    localparam logic [9:0] WY1        = 10'(WIN_Y1);

    if (WIN_X0 > WIN_X1 || WIN_X1 >= H_ACTIVE || WIN_Y0 > WIN_Y1 || WIN_Y1 >= V_ACTIVE)
    begin : g_bad_window
        $error("vga_timing_gen: display window must lie inside the active area");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || MEM_LATENCY > 4) begin : g_bad_timing
        $error("vga_timing_gen: totals exceed 10-bit counters or MEM_LATENCY > 4");
    end

    // Active-high region flags; all-zero means blank and inactive.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic win;
        logic fs;
    } flags_t;

    logic [9:0]        col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    flags_t            flags_s0, flags_dly;
    logic              col_wrap, row_wrap;

    // Stage 0: region decode and counters.
    always_comb begin
        flags_s0.hs  = (col_q >= HS_START) && (col_q < HS_END);
        flags_s0.vs  = (row_q >= VS_START) && (row_q < VS_END);
        flags_s0.act = (col_q < H_VIS_END) && (row_q < V_VIS_END);
        flags_s0.win = (col_q >= WX0) && (col_q <= WX1) && (row_q >= WY0) && (row_q <= WY1);
        flags_s0.fs  = (col_q == 10'd0) && (row_q == 10'd0);

        col_wrap = (col_q == H_LAST);
        row_wrap = (row_q == V_LAST);

        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (iPixelEn) begin
            col_d = col_wrap ? 10'd0 : col_q + 10'd1;
            if (col_wrap) begin
                row_d = row_wrap ? 10'd0 : row_q + 10'd1;
            end
            // Address advances past every window pixel, so it always names the current one.
            if (col_wrap && row_wrap) begin
                addr_d = '0;
            end else if (flags_s0.win) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            col_q  <= 10'd0;
            row_q  <= 10'd0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end

    // Flag delay line matching the memory read latency.
    if (MEM_LATENCY == 0) begin : g_no_dly
        assign flags_dly = flags_s0;
    end else begin : g_dly
        flags_t dly_q [MEM_LATENCY];
        flags_t dly_d [MEM_LATENCY];

        always_comb begin
            dly_d = dly_q;
            if (iPixelEn) begin
                dly_d[0] = flags_s0;
                for (int i = 1; i < MEM_LATENCY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end
        end

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                dly_q <= '{default: '0};
            end else begin
                dly_q <= dly_d;
            end
        end

        assign flags_dly = dly_q[MEM_LATENCY-1];
    end

    // Output register: delayed flags aligned with the read data.
    logic                 hsync_q, hsync_d, vsync_q, vsync_d;
    logic                 active_q, active_d, fstart_q, fstart_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;

    always_comb begin
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        active_d = active_q;
        fstart_d = fstart_q;
        rgb_d    = rgb_q;
        if (iPixelEn) begin
            hsync_d  = flags_dly.hs ? HS_POL : ~HS_POL;
            vsync_d  = flags_dly.vs ? VS_POL : ~VS_POL;
            active_d = flags_dly.act;
            fstart_d = flags_dly.fs;
            rgb_d    = flags_dly.win ? iColor : '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            active_q <= 1'b0;
            fstart_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            fstart_q <= fstart_d;
            rgb_q    <= rgb_d;
        end
    end

    assign oReadAddress = addr_q;
    assign oHSync       = hsync_q;
    assign oVSync       = vsync_q;
    assign oActive      = active_q;
    assign oFrameStart  = fstart_q;
    assign oVGA_Red     = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign oVGA_Green   = rgb_q[2*COLOR_W-1:COLOR_W];
    assign oVGA_Blue    = rgb_q[COLOR_W-1:0];
    assign oColumn      = col_q;
    assign oRow         = row_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance with MEM_LATENCY=3 fed by a latency-3
// memory model, plus a default-parameter instance with constant white input.
module tb_vga_timing_gen;

    // Small raster: 16 x 10, frame of 160 enabled cycles, window 4 x 4 at (2..5, 1..4).
    localparam int HT    = 16;
    localparam int FRAME = 160;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pixel_en = 1'b0;

    always #5 clk = ~clk;

    // Small instance
    logic [7:0] rd_addr;
    logic [2:0] icolor;
    logic       red, green, blue, hs, vs, act, fs;
    logic [9:0] col, row;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1),
        .WIN_X0(2), .WIN_X1(5), .WIN_Y0(1), .WIN_Y1(4),
        .COLOR_W(1), .ADDR_W(8), .MEM_LATENCY(LAT)
    ) u_dut (
        .Clock(clk), .Reset(rst), .iPixelEn(pixel_en),
        .oReadAddress(rd_addr), .iColor(icolor),
        .oVGA_Red(red), .oVGA_Green(green), .oVGA_Blue(blue),
        .oHSync(hs), .oVSync(vs), .oActive(act), .oFrameStart(fs),
        .oColumn(col), .oRow(row)
    );

    // Default instance
    logic [17:0] d_addr;
    logic        d_red, d_green, d_blue, d_hs, d_vs, d_act, d_fs;
    logic [9:0]  d_col, d_row;

    vga_timing_gen u_dflt (
        .Clock(clk), .Reset(rst), .iPixelEn(pixel_en),
        .oReadAddress(d_addr), .iColor(3'b111),
        .oVGA_Red(d_red), .oVGA_Green(d_green), .oVGA_Blue(d_blue),
        .oHSync(d_hs), .oVSync(d_vs), .oActive(d_act), .oFrameStart(d_fs),
        .oColumn(d_col), .oRow(d_row)
    );

    // Memory contents as a function of address.
    function automatic logic [2:0] mem_f(input logic [7:0] a);
        return a[2:0] ^ {1'b0, a[3], 1'b1};
    endfunction

    // Latency-3 read port model.
    logic [7:0] mp0 = '0, mp1 = '0, mp2 = '0;
    always @(posedge clk) begin
        if (pixel_en) begin
            mp0 <= rd_addr;
            mp1 <= mp0;
            mp2 <= mp1;
        end
    end
    assign icolor = mem_f(mp2);

    int n_checks = 0;
    int n_errors = 0;
    int n_en     = 0;  // enabled edges since reset release

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at n=%0d: observed %0h expected %0h", tag, n_en, obs, exp);
        end
    endtask

    // Window-linear address of the pixel at frame position s (window pixels before it).
    function automatic int win_addr(input int s);
        int h = s % HT;
        int v = s / HT;
        int x;
        if (v < 1) return 0;
        x = (h < 2) ? 0 : ((h > 5) ? 4 : h - 2);
        return (v - 1) * 4 + x;
    endfunction

    function automatic bit in_win(input int s);
        int h = s % HT;
        int v = s / HT;
        return (h >= 2) && (h <= 5) && (v >= 1) && (v <= 4);
    endfunction

    task automatic check_main();
        int s = n_en % FRAME;
        int p, h, v;
        chk("column", col, s % HT);
        chk("row", row, s / HT);
        // Address past the last window pixel is not a meaningful read address.
        if (s < 4 * HT + 6) chk("addr", rd_addr, win_addr(s));
        if (n_en < LAT + 1) begin
            chk("hs_blank", hs, 1);
            chk("vs_blank", vs, 0);
            chk("act_blank", act, 0);
            chk("fs_blank", fs, 0);
            chk("rgb_blank", {red, green, blue}, 0);
        end else begin
            p = (n_en - LAT - 1) % FRAME;
            h = p % HT;
            v = p / HT;
            chk("hsync", hs, (h >= 10 && h < 13) ? 0 : 1);
            chk("vsync", vs, (v >= 7 && v < 9) ? 1 : 0);
            chk("active", act, (h < 8 && v < 6) ? 1 : 0);
            chk("fstart", fs, (p == 0) ? 1 : 0);
            chk("rgb", {red, green, blue}, in_win(p) ? mem_f(8'(win_addr(p))) : 3'b000);
        end
    endtask

    task automatic check_dflt_reset();
        chk("d_hs_rst", d_hs, 1);
        chk("d_vs_rst", d_vs, 1);
        chk("d_act_rst", d_act, 0);
        chk("d_rgb_rst", {d_red, d_green, d_blue}, 0);
        chk("d_addr_rst", d_addr, 0);
        chk("d_col_rst", d_col, 0);
    endtask

    // One clock: drive enable, count enabled edges, sample on the falling edge.
    task automatic tick(input logic en_v);
        pixel_en = en_v;
        @(posedge clk);
        if (en_v) n_en++;
        @(negedge clk);
        check_main();
    endtask

    initial begin
        int guard;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_main();
        check_dflt_reset();
        rst = 1'b0;
        tick(1'b0);

        // Continuous enable: small raster over many frames, default raster spot checks.
        for (int k = 0; k < 40000; k++) begin
            tick(1'b1);
            case (n_en)
                2: begin
                    chk("d_act_00", d_act, 1);
                    chk("d_fs_00", d_fs, 1);
                end
                3:     chk("d_fs_01", d_fs, 0);
                657:   chk("d_hs_pre", d_hs, 1);
                658:   chk("d_hs_fall", d_hs, 0);
                753:   chk("d_hs_last", d_hs, 0);
                754:   chk("d_hs_rise", d_hs, 1);
                1457:  chk("d_hs_pre2", d_hs, 1);
                1458:  chk("d_hs_fall2", d_hs, 0);
                38464: chk("d_addr_64_48", d_addr, 0);
                38465: begin
                    chk("d_addr_65_48", d_addr, 1);
                    chk("d_rgb_63_48", {d_red, d_green, d_blue}, 3'b000);
                    chk("d_act_63_48", d_act, 1);
                end
                38466: chk("d_rgb_64_48", {d_red, d_green, d_blue}, 3'b111);
                38975: chk("d_addr_575_48", d_addr, 511);
                38977: chk("d_rgb_575_48", {d_red, d_green, d_blue}, 3'b111);
                38978: begin
                    chk("d_rgb_576_48", {d_red, d_green, d_blue}, 3'b000);
                    chk("d_act_576_48", d_act, 1);
                end
                39264: chk("d_addr_64_49", d_addr, 512);
                default: ;
            endcase
        end

        // Enable toggling every cycle: outputs must hold on disabled cycles.
        for (int k = 0; k < 2 * FRAME + 40; k++) begin
            tick((k % 2) == 0);
        end

        // Run to mid-frame (row 5, column 7), then reset asynchronously.
        guard = 0;
        while (!(((n_en % FRAME) / HT == 5) && ((n_en % FRAME) % HT == 7)) && guard < 2 * FRAME)
        begin
            tick(1'b1);
            guard++;
        end
        chk("reach_mid_frame", guard < 2 * FRAME, 1);
        #2;
        rst = 1'b1;
        #1;
        n_en = 0;
        check_main();
        check_dflt_reset();
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0);
        tick(1'b0);
        tick(1'b1);
        chk("first_col_after_rst", col, 1);
        for (int k = 0; k < 2 * FRAME + 20; k++) begin
            tick(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing and pixel-fetch controller. Successor to the fixed 640x480 controller. Generates horizontal and vertical sync with programmable timing and polarity, and produces a linear read address into video memory for a rectangular display window. Pipelines sync, blanking and colour so they stay aligned with a fixed-latency memory read. Sits between the video-memory read port and the VGA DAC pins; a pixel-clock enable lets it run from a faster system clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- HS_POL / VS_POL, 0 / 0, active level of oHSync / oVSync
- WIN_X0 / WIN_X1, 64 / 575, first / last window column, inclusive
- WIN_Y0 / WIN_Y1, 48 / 431, first / last window row, inclusive
- COLOR_W, 1, bits per colour channel
- ADDR_W, 18, read address width
- MEM_LATENCY, 1, enabled cycles from oReadAddress to valid iColor (range 0..4)

Ports:
- Clock  in  1  system clock
- Reset  in  1  asynchronous, active-high
- iPixelEn  in  1  pixel-clock enable; the whole block advances only when high
- oReadAddress  out  ADDR_W  video-memory read address
- iColor  in  3*COLOR_W  {R,G,B} read data from video memory
- oVGA_Red / oVGA_Green / oVGA_Blue  out  COLOR_W each  pixel colour
- oHSync / oVSync  out  1  sync outputs, polarity per parameter
- oActive  out  1  high while the output pixel is inside the visible area
- oFrameStart  out  1  one-enabled-cycle pulse with output pixel (0,0)
- oColumn  out  10  stage-0 column counter
- oRow  out  10  stage-0 row counter

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Defaults give 800 and 525.
- Stage 0: column counter 0..H_TOTAL-1 increments on each enabled cycle and wraps to 0. Row counter 0..V_TOTAL-1 increments when column wraps, and wraps to 0 after V_TOTAL-1.
- Per-line region order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical uses the same order, in lines.
- In window: (col in WIN_X0..WIN_X1) and (row in WIN_Y0..WIN_Y1). Window lies inside the active area; elaboration fails otherwise.
- Address counter: registered, no multiplier.
  - Increments by 1 on every enabled cycle whose stage-0 position is in window.
  - Resets to 0 when stage 0 wraps to (0,0).
  - Holds outside the window.
  - Maximum value is (WIN_X1-WIN_X0+1)*(WIN_Y1-WIN_Y0+1)-1; default 196607.
- oReadAddress equals the address counter, i.e. the address for the current stage-0 pixel.
- Delay line: hsync, vsync, active, in-window and frame-start flags are delayed MEM_LATENCY enabled cycles, then registered together with iColor.
- Colour outputs: iColor when the delayed in-window flag is set; 0 when outside the window or in blanking.
- iPixelEn low: counters, delay line and all outputs hold their values.
- No other state machine is used; region decode is combinational from the counters.

## Timing
- Reset (async, immediate):
  - counters = 0, address = 0
  - oHSync = ~HS_POL, oVSync = ~VS_POL
  - RGB = 0, oActive = 0, oFrameStart = 0
  - delay line cleared to blank/inactive
- Output latency: outputs for stage-0 position (h,v) appear MEM_LATENCY+1 enabled cycles after the counters hold (h,v).
- iColor sampled on the enabled cycle that is MEM_LATENCY enabled cycles after oReadAddress presented its address.
- Reset asserted mid-frame: outputs go to reset values without waiting for Clock. After release, the first enabled cycle produces counters = (1,0) on the next enabled edge.
- Frame period: H_TOTAL*V_TOTAL enabled cycles; default 420000.

## Test plan
- Defaults, iPixelEn=1, release reset → first oHSync falling edge after 658 cycles; low for 96 cycles; period 800.
- Defaults → oVSync low for 2 lines (1600 cycles) starting at row 490. oFrameStart pulses every 420000 cycles.
- Defaults, iColor=3'b111 constant → RGB=1 only on columns 64..575 of rows 48..431, otherwise 0. oActive high for 640x480 pixels per frame.
- Defaults → oReadAddress counts 0..511 on row 48, 512 at start of row 49, reaches 196607 at (575,431), and is 0 at the next frame's (0,0).
- iPixelEn toggling 1/0 every cycle → all periods doubled (hsync period 1600, frame 840000). Outputs unchanged on disabled cycles.
- MEM_LATENCY=3, iColor driven as a delayed function of oReadAddress → RGB matches the expected pattern with no pixel offset. Reset pulse at row 200 → immediate reset values, and a clean frame restarts afterwards.
